// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame constants and the odd-parity helper
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} ps2_state_t;

    localparam int PS2_FRAME_FALLS    = 11;
    localparam int PS2_INHIBIT_CYCLES = 5000;
    localparam int PS2_TIMEOUT_CYCLES = 1000000;
    localparam int PS2_RETRY_MAX      = 2;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 3-stage synchronisers and falling-edge detectors for the PS/2 pads
//   clk, clrn           : system clock, async active-low reset (sync chains reset to 1)
//   i_clk, i_data       : raw pad levels
//   o_clk, o_data       : synchronised levels
//   o_clk_fall, o_data_fall : one-cycle falling-edge strobes
module ps2_sync_edge (
    input  logic clk,
    input  logic clrn,
    input  logic i_clk,
    input  logic i_data,
    output logic o_clk,
    output logic o_data,
    output logic o_clk_fall,
    output logic o_data_fall
);
    logic [2:0] r_clk_sync;
    logic [2:0] r_data_sync;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 3'b111;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], i_clk};
            r_data_sync <= {r_data_sync[1:0], i_data};
        end
    end

    assign o_clk       = r_clk_sync[1];
    assign o_data      = r_data_sync[1];
    assign o_clk_fall  = r_clk_sync[2] & ~r_clk_sync[1];
    assign o_data_fall = r_data_sync[2] & ~r_data_sync[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain pull-low enables
//   clk, clrn                 : system clock, async active-low reset
//   ps2_clk, ps2_data         : pad levels
//   tx_data, tx_valid, tx_ready : command byte handshake (accepted only in IDLE)
//   ps2_clk_oe, ps2_data_oe   : 1 = pull line low
//   busy                      : transmit in progress
//   done, ack_err, timeout    : one-cycle completion pulses, exactly one per accepted byte
//   Optional: define PS2_TX_RETRY_EN to resend up to RETRY_MAX times before reporting failure
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int RETRY_MAX      = PS2_RETRY_MAX
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);
    localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_t r_state, w_state_n;
    logic [IW-1:0] r_inh_cnt, w_inh_cnt_n;
    logic [TW-1:0] r_to_cnt, w_to_cnt_n;
    logic [3:0]    r_bits, w_bits_n;
    logic [7:0]    r_byte;
    logic          r_par;
    logic          r_data_oe, w_data_oe_n;
    logic          r_done, r_ack_err, r_timeout;
    logic          w_done_n, w_nak, w_timed, w_to_hit, w_fail, w_retry, w_accept;
    logic          w_clk_s, w_data_s, w_clk_fall, w_data_fall, w_unused;

    ps2_sync_edge u_sync (
        .clk         (clk),
        .clrn        (clrn),
        .i_clk       (ps2_clk),
        .i_data      (ps2_data),
        .o_clk       (w_clk_s),
        .o_data      (w_data_s),
        .o_clk_fall  (w_clk_fall),
        .o_data_fall (w_data_fall)
    );

    assign w_unused = w_data_fall & (RETRY_MAX != 0);

`ifdef PS2_TX_RETRY_EN
    localparam int RW = $clog2(RETRY_MAX + 1) + 1;
    logic [RW-1:0] r_retry;
    assign w_retry = r_retry != RW'(RETRY_MAX);
`else
    assign w_retry = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) & tx_valid;
    assign w_timed  = (r_state == RTS) | (r_state == SEND) | (r_state == ACK) | (r_state == WAIT_IDLE);
    // Timeout wins over any fall or line-idle event seen on the same cycle.
    assign w_to_hit = w_timed & (r_to_cnt == TO_LAST);
    assign w_fail   = w_to_hit | w_nak;

    always_comb begin
        w_state_n   = r_state;
        w_inh_cnt_n = '0;
        w_to_cnt_n  = w_timed ? r_to_cnt + 1'b1 : '0;
        w_bits_n    = r_bits;
        w_data_oe_n = r_data_oe;
        w_done_n    = 1'b0;
        w_nak       = 1'b0;
        case (r_state)
            IDLE: begin
                w_bits_n    = '0;
                w_data_oe_n = 1'b0;
                w_state_n   = tx_valid ? INHIBIT : IDLE;
            end
            INHIBIT: begin
                w_inh_cnt_n = r_inh_cnt + 1'b1;
                if (r_inh_cnt == INH_LAST) begin
                    w_state_n   = RTS;
                    w_data_oe_n = 1'b1;
                end
            end
            RTS: begin
                w_bits_n  = '0;
                w_state_n = SEND;
            end
            SEND: begin
                if (w_clk_fall) begin
                    w_bits_n    = r_bits + 1'b1;
                    w_data_oe_n = r_bits < 4'd8 ? ~r_byte[r_bits[2:0]] : r_bits == 4'd8 ? ~r_par : 1'b0;
                    w_state_n   = r_bits == 4'(PS2_FRAME_FALLS - 2) ? ACK : SEND;
                end
            end
            ACK: begin
                if (w_clk_fall) begin
                    w_bits_n  = r_bits + 1'b1;
                    w_nak     = w_data_s;
                    w_state_n = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                w_done_n  = w_clk_s & w_data_s;
                w_state_n = w_done_n ? IDLE : WAIT_IDLE;
            end
            default: w_state_n = IDLE;
        endcase
        if (w_fail) begin
            w_state_n   = w_retry ? INHIBIT : IDLE;
            w_data_oe_n = 1'b0;
            w_bits_n    = '0;
            w_inh_cnt_n = '0;
            w_to_cnt_n  = '0;
            w_done_n    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= IDLE;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_bits    <= '0;
            r_byte    <= '0;
            r_par     <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            r_retry   <= '0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_inh_cnt <= w_inh_cnt_n;
            r_to_cnt  <= w_to_cnt_n;
            r_bits    <= w_bits_n;
            r_data_oe <= w_data_oe_n;
            r_done    <= w_done_n;
            r_ack_err <= w_nak & ~w_to_hit & ~w_retry;
            r_timeout <= w_to_hit & ~w_retry;
            if (w_accept) begin
                r_byte <= tx_data;
                r_par  <= odd_parity(tx_data);
            end
`ifdef PS2_TX_RETRY_EN
            r_retry   <= w_accept ? '0 : (w_fail & w_retry) ? r_retry + 1'b1 : r_retry;
`endif
        end
    end

    assign tx_ready    = r_state == IDLE;
    assign busy        = ~tx_ready;
    assign ps2_clk_oe  = (r_state == INHIBIT) | (r_state == RTS);
    assign ps2_data_oe = r_data_oe;
    assign done        = r_done;
    assign ack_err     = r_ack_err;
    assign timeout     = r_timeout;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a PS/2 device model for ps2_host_tx
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TO  = 2000;
    localparam int H   = 10;
`ifdef PS2_TX_RETRY_EN
    localparam int NAK_FRAMES = 3;
    localparam int TO_SPAN    = TO + 2 * (TO + INH);
`else
    localparam int NAK_FRAMES = 1;
    localparam int TO_SPAN    = TO;
`endif

    typedef struct {
        logic [2:0] kind;
        int         frames;
        logic [9:0] oe;
    } exp_t;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk, ps2_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout;

    logic       dev_clk_low, dev_data_low, dev_active;
    logic       skip = 1'b0;
    int         dev_mode = 0;
    int         dev_frames, dev_falls;
    logic [9:0] cap, last_cap;

    int   n_pass = 0, n_total = 0, n_resp = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [2:0] kind, input int frames, input logic [9:0] oe);
        exp_t e;
        e = '{kind, frames, oe};
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] b);
        int i = 0;
        @(negedge clk);
        while (!tx_ready && i < 20000) begin @(negedge clk); i++; end
        chk("issue_ready", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        int i = 0;
        while (n_resp < target && i < 20000) begin @(negedge clk); i++; end
        chk("resp_count", n_resp, target);
    endtask

    // Device: clocks a frame whenever the host has released clock with the start bit down.
    // mode 0 = ACK, 1 = NAK (data left high at fall 11), 2 = silent.
    initial begin
        dev_clk_low = 0; dev_data_low = 0; dev_active = 0;
        dev_frames = 0; dev_falls = 0; cap = '0; last_cap = '0;
        forever begin
            @(negedge clk);
            if (ps2_data_oe && !ps2_clk_oe && dev_mode != 2) begin
                dev_active = 1;
                dev_falls  = 0;
                for (int k = 1; k <= 11; k++) begin
                    if (k == 11 && dev_mode == 0) dev_data_low = 1;
                    repeat (H) @(negedge clk);
                    dev_clk_low = 1;
                    dev_falls   = k;
                    if (k == 11 && !skip) begin
                        dev_frames++;
                        last_cap = cap;
                    end
                    repeat (H) @(negedge clk);
                    if (k <= 10) cap[k-1] = ps2_data_oe;
                    dev_clk_low = 0;
                end
                dev_data_low = 0;
                dev_active   = 0;
            end
        end
    end

    // Monitor: every completion pulse pops one expectation.
    initial begin
        exp_t e;
        int   seen_frames = 0;
        forever begin
            @(negedge clk);
            if (done | ack_err | timeout) begin
                if (exp_q.size() == 0) chk("unexpected_pulse", {done, ack_err, timeout}, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", {done, ack_err, timeout}, e.kind);
                    chk("frame_count", dev_frames - seen_frames, e.frames);
                    if (e.frames != 0) chk("frame_oe_bits", last_cap, e.oe);
                    seen_frames = dev_frames;
                    n_resp++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int i, inh, rts, span;
        clrn = 0; tx_valid = 0; tx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_pulses", {done, ack_err, timeout}, 0);
        #2 clrn = 1;

        dev_mode = 0;
        push(3'b100, 1, 10'h012);
        issue(8'hED);
        wait_resp(1);
        chk("ed_clk_oe", ps2_clk_oe, 0);
        chk("ed_data_oe", ps2_data_oe, 0);

        dev_mode = 1;
        push(3'b010, NAK_FRAMES, 10'h1FE);
        issue(8'h01);
        i = 0;
        @(negedge clk);
        while (!ack_err && i < 20000) begin @(negedge clk); i++; end
        chk("nak_pulse", ack_err, 1);
        chk("nak_clk_oe", ps2_clk_oe, 0);
        chk("nak_data_oe", ps2_data_oe, 0);
        chk("nak_busy", busy, 0);
        @(negedge clk);
        chk("nak_ready_next", tx_ready, 1);
        chk("nak_pulse_once", ack_err, 0);
        wait_resp(2);

        dev_mode = 2;
        push(3'b001, 0, 10'h000);
        issue(8'hFF);
        inh = 0; rts = 0;
        @(negedge clk);
        while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin inh++; @(negedge clk); end
        while (ps2_clk_oe && ps2_data_oe && rts < 1000) begin rts++; @(negedge clk); end
        span = rts;
        while (!timeout && span < 20000) begin @(negedge clk); span++; end
        chk("inhibit_cycles", inh, INH);
        chk("rts_cycles", rts, 1);
        chk("timeout_span", span, TO_SPAN);
        chk("to_clk_oe", ps2_clk_oe, 0);
        chk("to_data_oe", ps2_data_oe, 0);
        wait_resp(3);

        dev_mode = 0;
        push(3'b100, 1, 10'h055);
        push(3'b100, 1, 10'h0AA);
        i = 0;
        @(negedge clk);
        while (!tx_ready && i < 1000) begin @(negedge clk); i++; end
        tx_data = 8'hAA; tx_valid = 1;
        @(posedge clk);
        #1 tx_data = 8'h55;
        i = 0;
        @(negedge clk);
        chk("held_busy", tx_ready, 0);
        while (!tx_ready && i < 20000) begin @(negedge clk); i++; end
        chk("held_ready", tx_ready, 1);
        @(posedge clk);
        #1 tx_valid = 0;
        wait_resp(5);

        skip = 1;
        issue(8'h00);
        i = 0;
        while (dev_falls != 4 && i < 5000) begin @(negedge clk); i++; end
        chk("reached_fall4", dev_falls, 4);
        repeat (5) @(negedge clk);
        chk("pre_reset_data_oe", ps2_data_oe, 1);
        #2 clrn = 0;
        #1;
        chk("async_clk_oe", ps2_clk_oe, 0);
        chk("async_data_oe", ps2_data_oe, 0);
        chk("async_busy", busy, 0);
        repeat (3) @(negedge clk);
        #2 clrn = 1;
        @(negedge clk);
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_busy", busy, 0);
        i = 0;
        while (dev_active && i < 5000) begin @(negedge clk); i++; end
        chk("dev_finished", dev_active, 0);
        skip = 0;

        push(3'b100, 1, 10'h0C3);
        issue(8'h3C);
        wait_resp(6);
        repeat (20) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
